// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit, also used by the
// instruction decoder and the issue control FSM.
package mul_div_unit_pkg;

    localparam int MDU_WIDTH  = 32;
    localparam int MDU_REG_AW = 5;

    typedef enum logic [1:0] {
        OP_MULLO = 2'b00,
        OP_MULHI = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_WB   = 2'b10
    } mdu_state_e;

    // Divide ops share the upper encoding bit.
    function automatic logic op_is_div(input mdu_op_e op);
        return op[1];
    endfunction

    // Ops that return the hi/remainder word rather than the lo/quotient word.
    function automatic logic op_takes_hi(input mdu_op_e op);
        return (op == OP_MULHI) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/mul_div_unit_step.sv
// One combinational iteration of the shared datapath: a shift-add multiply
// step or a restoring-divide step, selected by i_div.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi_next,
    output logic [WIDTH-1:0] o_lo_next
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;

    // Multiply: conditional add with the carry kept, then {carry,hi,lo} >> 1.
    assign w_sum = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_b} : {(WIDTH+1){1'b0}});

    // Divide: the remainder after a successful trial is below b, so the
    // subtraction only needs WIDTH bits once the compare has passed.
    assign w_shift = {i_hi, i_lo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, i_b});
    assign w_diff  = w_shift[WIDTH-1:0] - i_b;

    always_comb begin
        o_hi_next = w_sum[WIDTH:1];
        o_lo_next = {w_sum[0], i_lo[WIDTH-1:1]};
        if (i_div) begin
            o_hi_next = w_ge ? w_diff : w_shift[WIDTH-1:0];
            o_lo_next = {i_lo[WIDTH-2:0], w_ge};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-cycle unsigned multiply/divide unit with a single registered
// register-file writeback (active-low enable) and busy/done for issue stall.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH  = MDU_WIDTH,
    parameter int REG_AW = MDU_REG_AW
) (
    input  logic              clk,
    input  logic              rstd,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [REG_AW-1:0] dst,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  wr,
    output logic [REG_AW-1:0] wa,
    output logic              wren
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mdu_state_e        r_state;
    mdu_op_e           r_op;
    logic [REG_AW-1:0] r_dst;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_hi;
    logic [WIDTH-1:0]  r_lo;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic              r_done;
    logic              r_wren;
    logic [WIDTH-1:0]  r_wr;
    logic [REG_AW-1:0] r_wa;

    logic [WIDTH-1:0]  w_hi_next;
    logic [WIDTH-1:0]  w_lo_next;
    logic [WIDTH-1:0]  w_result;

    mdu_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_div     (op_is_div(r_op)),
        .i_hi      (r_hi),
        .i_lo      (r_lo),
        .i_b       (r_b),
        .o_hi_next (w_hi_next),
        .o_lo_next (w_lo_next)
    );

    // The final iteration's result is written straight into the output register.
    assign w_result = op_takes_hi(r_op) ? w_hi_next : w_lo_next;

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            r_state <= ST_IDLE;
            r_op    <= OP_MULLO;
            r_dst   <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_wren  <= 1'b1;
            r_wr    <= '0;
            r_wa    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op    <= mdu_op_e'(op);
                        r_dst   <= dst;
                        r_b     <= b;
                        r_hi    <= '0;
                        r_lo    <= a;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_hi  <= w_hi_next;
                    r_lo  <= w_lo_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_wr    <= w_result;
                        r_wa    <= r_dst;
                        r_done  <= 1'b1;
                        // Register 0 is hardwired; keep the enable inactive.
                        r_wren  <= (r_dst == '0);
                        r_state <= ST_WB;
                    end
                end
                ST_WB: begin
                    r_done  <= 1'b0;
                    r_wren  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign wr   = r_wr;
    assign wa   = r_wa;
    assign wren = r_wren;

endmodule
